otter_pipe_ctrl: RTL and testbench
==================================

Name: otter_pipe_ctrl

Overview:
- Parametrised pipeline control unit for the pipelined OTTER RV32I core.
- Owns per-stage valid bits and destination-register tags for every pipeline register.
- Detects RAW hazards and generates EX-stage forwarding selects.
- Generates load-use stalls, whole-pipe freeze on memory busy, and flushes on taken branch/jump; replaces ad-hoc invalid/stall flops in the CPU top.

Parameters:
- NSTAGES, 4, number of pipeline registers: stage 0 = IF/DE, 1 = DE/EX, 2 = EX/MEM, ..., NSTAGES-1 = last (writes RF); legal range >= 3
- LOAD_STAGE, 3, first stage whose register holds load data; legal range 2..NSTAGES-1
- RA_W, 5, register address width
- SEL_W, $clog2(NSTAGES), forwarding select width

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- de_rs1  in  RA_W  rs1 address of instruction in stage 0
- de_rs2  in  RA_W  rs2 address of instruction in stage 0
- de_rs1_used  in  1  stage-0 instruction reads rs1
- de_rs2_used  in  1  stage-0 instruction reads rs2
- de_rd  in  RA_W  rd of stage-0 instruction
- de_reg_write  in  1  stage-0 instruction writes RF
- de_is_load  in  1  stage-0 instruction is a load
- ex_br_taken  in  1  EX redirect (branch taken / JAL / JALR), meaningful only when valid[1]
- mem_busy  in  1  memory not ready; freeze entire pipe
- valid  out  NSTAGES  per-stage valid bits
- stall_if  out  1  hold PC and IF/DE register
- stall_de  out  1  hold stage-0 contents; bubble into stage 1
- freeze  out  1  hold all stages (= mem_busy)
- flush  out  1  redirect accepted this cycle
- fwd_a_sel  out  SEL_W  EX operand A source: 0 = RF/latched value, j = stage j result
- fwd_b_sel  out  SEL_W  same for operand B
- rf_we  out  1  valid[NSTAGES-1] & reg_write tag of last stage

Behaviour:
- Clock and reset: single clock CLK; reset RESET is synchronous and active-high.
- Reset: all valid = 0; all tags (rd, reg_write, is_load, rs1, rs2, rs_used) = 0; all outputs therefore 0.
- Tag pipeline:
  - Stage k >= 1 holds rd, reg_write, is_load, rs1/rs2 and used flags.
  - Stage 0 tags are the de_* inputs.
  - On advance, stage k tags and valid are copied into stage k+1.
- Hazard qualification: producer in stage j matches operand r iff valid[j] & reg_write_j & rd_j == r & r != 0 & used.
- Load-use stall:
  - Raised when valid[0] and stage-0 rs matches a producer in stage k (1 <= k <= LOAD_STAGE-2) with is_load.
  - stall_if = stall_de = 1; next edge: stage 0 and PC hold, valid[1] <= 0, stages >= 2 advance.
  - Default parameters: stall exactly 1 cycle behind a load.
- Forwarding (combinational, for the instruction in stage 1):
  - Search stages 2..NSTAGES-1, youngest (lowest index) match wins.
  - Stage j may source only if !is_load_j or j >= LOAD_STAGE.
  - No match -> 0.
  - Writes from stage NSTAGES-1 must be visible to same-cycle RF reads (write-first RF); no forwarding term for retired instructions.
- Flush:
  - flush = valid[1] & ex_br_taken & !mem_busy.
  - Next edge: valid[0] <= 0 and valid[1] <= 0; stages >= 2 advance normally.
  - Flush overrides load-use stall: stall_if/stall_de forced 0 when flush.
- Freeze:
  - mem_busy = 1 holds every valid bit and tag; stall_if = 1; flush = 0; rf_we still reported (the last stage is not re-written since it is held).
  - The integrating CPU treats freeze cycles as no-write.
  - mem_busy overrides flush and load-use for that cycle; both are re-evaluated when freeze drops.
- Normal advance: valid[0] <= 1 (new fetch), valid[k+1] <= valid[k].
- Reset mid-operation: RESET overrides all; valid cleared the same edge.
- Same rd in multiple stages: youngest wins (e.g. stages 2 and 3 both match -> sel = 2).

Test Plan:
- Reset, then release: valid = 4'b0000 -> 0001 -> 0011 -> 0111 -> 1111 on successive edges; rf_we follows valid[3] & reg_write.
- `add x5` followed by `sub x6,x5,x1`: when sub is in stage 1 with add in stage 2 -> fwd_a_sel = 2, fwd_b_sel = 0; one cycle later, a dependent third instruction -> fwd_a_sel = 3.
- `lw x7` in stage 1 with `add x8,x7,x7` in stage 0 -> stall_if = stall_de = 1 for exactly 1 cycle, valid[1] = 0 next cycle, then add in EX gets fwd_a_sel = fwd_b_sel = 3.
- ex_br_taken = 1 with valid[1] = 1 -> flush = 1; next cycle valid[1:0] = 00, valid[2] = 1; the same cycle with a load-use match -> stall_if = 0.
- mem_busy held 3 cycles mid-stream -> valid and fwd selects unchanged for 3 cycles; resumes advancing on the 4th edge; ex_br_taken asserted during busy is ignored until busy drops.
- Hazards against x0 (rd = 0, rs1 = 0) never stall or forward; NSTAGES = 5, LOAD_STAGE = 4: a load in stage 1 or 2 -> stall each cycle until the load reaches stage 3 (2 stall cycles).

Source files
------------

// File: rtl/otter_pipe_ctrl.sv
// otter_pipe_ctrl: pipeline control for the pipelined OTTER RV32I core.
// Owns the per-stage valid bits and destination tags. From them it derives
// RAW forwarding selects for EX, load-use stalls, the whole-pipe freeze on a
// busy memory, and flushes on a taken redirect.
module otter_pipe_ctrl #(
    parameter int NSTAGES    = 4,
    parameter int LOAD_STAGE = 3,
    parameter int RA_W       = 5,
    parameter int SEL_W      = $clog2(NSTAGES)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [RA_W-1:0]    de_rs1,
    input  logic [RA_W-1:0]    de_rs2,
    input  logic               de_rs1_used,
    input  logic               de_rs2_used,
    input  logic [RA_W-1:0]    de_rd,
    input  logic               de_reg_write,
    input  logic               de_is_load,
    input  logic               ex_br_taken,
    input  logic               mem_busy,
    output logic [NSTAGES-1:0] valid,
    output logic               stall_if,
    output logic               stall_de,
    output logic               freeze,
    output logic               flush,
    output logic [SEL_W-1:0]   fwd_a_sel,
    output logic [SEL_W-1:0]   fwd_b_sel,
    output logic               rf_we
);

    // Stage 0 tags come straight from the decoder; stages 1.. are registered.
    logic [NSTAGES-1:0] valid_r;
    logic [RA_W-1:0]    rd_r [1:NSTAGES-1];
    logic [NSTAGES-1:1] reg_write_r;
    logic [NSTAGES-1:1] is_load_r;
    // Source tags are only consulted for the instruction sitting in EX.
    logic [RA_W-1:0]    rs1_r;
    logic [RA_W-1:0]    rs2_r;
    logic               rs1_used_r;
    logic               rs2_used_r;

    logic               load_use_s;
    logic               flush_s;
    logic               stall_de_s;
    logic               stall_if_s;
    logic               issue_s;
    logic [SEL_W-1:0]   fwd_a_s;
    logic [SEL_W-1:0]   fwd_b_s;

    // A producer matches a consumer operand only if it is live, writes the RF,
    // targets the same register, that register is not x0 and the operand is read.
    function automatic logic hazard_match(
        input logic            prod_valid,
        input logic            prod_we,
        input logic [RA_W-1:0] prod_rd,
        input logic [RA_W-1:0] src,
        input logic            src_used
    );
        return prod_valid & prod_we & (prod_rd == src) &
               (src != {RA_W{1'b0}}) & src_used;
    endfunction

    // Load-use detection: stage-0 operand depends on a load whose data is not yet available.
    always_comb begin
        load_use_s = 1'b0;
        for (int k = 1; k <= LOAD_STAGE - 2; k++) begin
            load_use_s = load_use_s | (is_load_r[k] &
                (hazard_match(valid_r[k], reg_write_r[k], rd_r[k], de_rs1, de_rs1_used) |
                 hazard_match(valid_r[k], reg_write_r[k], rd_r[k], de_rs2, de_rs2_used)));
        end
        load_use_s = load_use_s & valid_r[0];
    end

    // Priority between freeze, flush and load-use stall.
    always_comb begin
        flush_s    = valid_r[1] & ex_br_taken & ~mem_busy;
        stall_de_s = load_use_s & ~flush_s & ~mem_busy;
        stall_if_s = stall_de_s | mem_busy;
        issue_s    = valid_r[0] & ~stall_de_s & ~flush_s;
    end

    // EX forwarding: scan oldest to youngest so the youngest eligible producer wins.
    always_comb begin
        fwd_a_s = {SEL_W{1'b0}};
        fwd_b_s = {SEL_W{1'b0}};
        for (int j = NSTAGES - 1; j >= 2; j--) begin
            fwd_a_s = ((!is_load_r[j] || j >= LOAD_STAGE) &&
                       hazard_match(valid_r[j], reg_write_r[j], rd_r[j], rs1_r, rs1_used_r))
                      ? SEL_W'(j) : fwd_a_s;
            fwd_b_s = ((!is_load_r[j] || j >= LOAD_STAGE) &&
                       hazard_match(valid_r[j], reg_write_r[j], rd_r[j], rs2_r, rs2_used_r))
                      ? SEL_W'(j) : fwd_b_s;
        end
    end

    // Valid/tag pipeline: reset, freeze hold, or advance with bubble/flush insertion.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_r     <= {NSTAGES{1'b0}};
            reg_write_r <= {(NSTAGES-1){1'b0}};
            is_load_r   <= {(NSTAGES-1){1'b0}};
            for (int k = 1; k < NSTAGES; k++) begin
                rd_r[k] <= {RA_W{1'b0}};
            end
            rs1_r      <= {RA_W{1'b0}};
            rs2_r      <= {RA_W{1'b0}};
            rs1_used_r <= 1'b0;
            rs2_used_r <= 1'b0;
        end else if (mem_busy) begin
            // Frozen: every valid bit and tag keeps its value.
        end else begin
            // Stage 0 holds on a stall, empties on a flush, otherwise takes a new fetch.
            valid_r[0] <= stall_de_s ? valid_r[0] : ~flush_s;
            // Bubbles and flushed slots enter stage 1 with cleared tags.
            valid_r[1]     <= issue_s;
            rd_r[1]        <= issue_s ? de_rd : {RA_W{1'b0}};
            reg_write_r[1] <= issue_s & de_reg_write;
            is_load_r[1]   <= issue_s & de_is_load;
            rs1_r          <= issue_s ? de_rs1 : {RA_W{1'b0}};
            rs2_r          <= issue_s ? de_rs2 : {RA_W{1'b0}};
            rs1_used_r     <= issue_s & de_rs1_used;
            rs2_used_r     <= issue_s & de_rs2_used;
            for (int k = 2; k < NSTAGES; k++) begin
                valid_r[k]     <= valid_r[k-1];
                rd_r[k]        <= rd_r[k-1];
                reg_write_r[k] <= reg_write_r[k-1];
                is_load_r[k]   <= is_load_r[k-1];
            end
        end
    end

    assign valid     = valid_r;
    assign stall_if  = stall_if_s;
    assign stall_de  = stall_de_s;
    assign freeze    = mem_busy;
    assign flush     = flush_s;
    assign fwd_a_sel = fwd_a_s;
    assign fwd_b_sel = fwd_b_s;
    assign rf_we     = valid_r[NSTAGES-1] & reg_write_r[NSTAGES-1];

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// Testbench for otter_pipe_ctrl: directed cycle-by-cycle stimulus with a
// scoreboard queue of expected output values drained each cycle.
module tb_otter_pipe_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] de_rs1, de_rs2, de_rd;
    logic       de_rs1_used, de_rs2_used, de_reg_write, de_is_load;
    logic       ex_br_taken, mem_busy;

    logic [3:0] valid;
    logic       stall_if, stall_de, freeze, flush, rf_we;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    logic [4:0] valid2;
    logic       stall_if2, stall_de2, freeze2, flush2, rf_we2;
    logic [2:0] fwd_a_sel2, fwd_b_sel2;

    otter_pipe_ctrl dut (
        .CLK(CLK), .RESET(RESET),
        .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .de_rd(de_rd), .de_reg_write(de_reg_write), .de_is_load(de_is_load),
        .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
        .valid(valid), .stall_if(stall_if), .stall_de(stall_de),
        .freeze(freeze), .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .rf_we(rf_we)
    );

    otter_pipe_ctrl #(.NSTAGES(5), .LOAD_STAGE(4)) dut5 (
        .CLK(CLK), .RESET(RESET),
        .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .de_rd(de_rd), .de_reg_write(de_reg_write), .de_is_load(de_is_load),
        .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
        .valid(valid2), .stall_if(stall_if2), .stall_de(stall_de2),
        .freeze(freeze2), .flush(flush2),
        .fwd_a_sel(fwd_a_sel2), .fwd_b_sel(fwd_b_sel2), .rf_we(rf_we2)
    );

    // Free-running clock, period 10.
    always #5 CLK = ~CLK;

    localparam int S_V = 0, S_SIF = 1, S_SDE = 2, S_FL = 3, S_FA = 4, S_FB = 5,
                   S_WE = 6, S_FZ = 7, S_V2 = 8, S_SIF2 = 9, S_SDE2 = 10,
                   S_FA2 = 11, S_FB2 = 12, S_WE2 = 13;

    int    checks_cnt = 0;
    int    errors_cnt = 0;
    string tag_q[$];
    int    sig_q[$];
    int    val_q[$];

    task automatic check_val(input string tag, input integer observed, input integer expected);
        checks_cnt++;
        if (observed !== expected) begin
            errors_cnt++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic integer observe(input int sig);
        case (sig)
            S_V:     observe = integer'(valid);
            S_SIF:   observe = integer'(stall_if);
            S_SDE:   observe = integer'(stall_de);
            S_FL:    observe = integer'(flush);
            S_FA:    observe = integer'(fwd_a_sel);
            S_FB:    observe = integer'(fwd_b_sel);
            S_WE:    observe = integer'(rf_we);
            S_FZ:    observe = integer'(freeze);
            S_V2:    observe = integer'(valid2);
            S_SIF2:  observe = integer'(stall_if2);
            S_SDE2:  observe = integer'(stall_de2);
            S_FA2:   observe = integer'(fwd_a_sel2);
            S_FB2:   observe = integer'(fwd_b_sel2);
            S_WE2:   observe = integer'(rf_we2);
            default: observe = -1;
        endcase
    endfunction

    task automatic exp_out(input string tag, input int sig, input int val);
        tag_q.push_back(tag);
        sig_q.push_back(sig);
        val_q.push_back(val);
    endtask

    // Let combinational outputs settle, then compare everything queued for this cycle.
    task automatic drain();
        string t;
        int    s;
        int    v;
        #1;
        while (sig_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sig_q.pop_front();
            v = val_q.pop_front();
            check_val(t, observe(s), v);
        end
    endtask

    task automatic next_cyc();
        @(negedge CLK);
    endtask

    task automatic drive(input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit rw, input bit ld);
        de_rs1       = 5'(rs1);
        de_rs1_used  = u1;
        de_rs2       = 5'(rs2);
        de_rs2_used  = u2;
        de_rd        = 5'(rd);
        de_reg_write = rw;
        de_is_load   = ld;
    endtask

    task automatic nop();
        drive(0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        RESET = 1'b1; ex_br_taken = 1'b0; mem_busy = 1'b0;
        nop();
        repeat (2) @(posedge CLK);

        // Reset state
        next_cyc();
        exp_out("rst_valid", S_V, 0);   exp_out("rst_stall_if", S_SIF, 0);
        exp_out("rst_stall_de", S_SDE, 0); exp_out("rst_flush", S_FL, 0);
        exp_out("rst_fwd_a", S_FA, 0);  exp_out("rst_fwd_b", S_FB, 0);
        exp_out("rst_rf_we", S_WE, 0);  exp_out("rst_freeze", S_FZ, 0);
        exp_out("rst_valid5", S_V2, 0);
        drain();
        RESET = 1'b0;

        // Fill sequence; x1 writer issued in the first live cycle
        next_cyc(); drive(0, 0, 0, 0, 1, 1, 0);
        exp_out("fill1_valid", S_V, 1); exp_out("fill1_we", S_WE, 0); drain();
        next_cyc(); nop(); exp_out("fill2_valid", S_V, 3);  exp_out("fill2_we", S_WE, 0); drain();
        next_cyc(); nop(); exp_out("fill3_valid", S_V, 7);  exp_out("fill3_we", S_WE, 0); drain();
        next_cyc(); nop(); exp_out("fill4_valid", S_V, 15); exp_out("fill4_we", S_WE, 1); drain();
        next_cyc(); nop(); exp_out("fill5_we", S_WE, 0); drain();

        // add x5,x2,x3 ; sub x6,x5,x1 ; and x9,x5,x6
        next_cyc(); drive(2, 1, 3, 1, 5, 1, 0); exp_out("add_stall", S_SIF, 0); drain();
        next_cyc(); drive(5, 1, 1, 1, 6, 1, 0); exp_out("add_ex_fwd_a", S_FA, 0); drain();
        next_cyc(); drive(5, 1, 6, 1, 9, 1, 0);
        exp_out("sub_fwd_a", S_FA, 2); exp_out("sub_fwd_b", S_FB, 0); drain();
        next_cyc(); nop();
        exp_out("and_fwd_a", S_FA, 3); exp_out("and_fwd_b", S_FB, 2);
        exp_out("and_rf_we", S_WE, 1); drain();

        // Two writers of x5 back to back: youngest wins
        next_cyc(); drive(0, 0, 0, 0, 5, 1, 0); drain();
        next_cyc(); drive(0, 0, 0, 0, 5, 1, 0); drain();
        next_cyc(); drive(5, 1, 5, 1, 13, 1, 0); drain();
        next_cyc(); nop();
        exp_out("young_fwd_a", S_FA, 2); exp_out("young_fwd_b", S_FB, 2); drain();

        // x0 never stalls or forwards
        next_cyc(); drive(2, 1, 0, 0, 0, 1, 1); drain();
        next_cyc(); drive(0, 1, 0, 0, 0, 1, 0);
        exp_out("x0_stall_if", S_SIF, 0); exp_out("x0_stall_de", S_SDE, 0); drain();
        next_cyc(); drive(0, 1, 0, 1, 14, 1, 0); exp_out("x0_fwd_a1", S_FA, 0); drain();
        next_cyc(); nop();
        exp_out("x0_fwd_a2", S_FA, 0); exp_out("x0_fwd_b2", S_FB, 0); drain();

        // lw x7 ; add x8,x7,x7 -> one stall cycle then forward from stage 3
        next_cyc(); drive(2, 1, 0, 0, 7, 1, 1); drain();
        next_cyc(); drive(7, 1, 7, 1, 8, 1, 0);
        exp_out("lu_stall_if", S_SIF, 1); exp_out("lu_stall_de", S_SDE, 1);
        exp_out("lu_flush", S_FL, 0); exp_out("lu_valid", S_V, 15); drain();
        next_cyc(); drive(7, 1, 7, 1, 8, 1, 0);
        exp_out("lu2_stall_if", S_SIF, 0); exp_out("lu2_stall_de", S_SDE, 0);
        exp_out("lu2_valid", S_V, 13); drain();
        next_cyc(); nop();
        exp_out("lu3_fwd_a", S_FA, 3); exp_out("lu3_fwd_b", S_FB, 3);
        exp_out("lu3_valid", S_V, 11); exp_out("lu3_rf_we", S_WE, 1); drain();

        // Redirect with a simultaneous load-use match: flush wins
        next_cyc(); drive(0, 0, 0, 0, 10, 1, 1); drain();
        next_cyc(); drive(10, 1, 0, 0, 11, 1, 0); ex_br_taken = 1'b1;
        exp_out("br_flush", S_FL, 1); exp_out("br_stall_if", S_SIF, 0);
        exp_out("br_stall_de", S_SDE, 0); exp_out("br_valid", S_V, 15); drain();
        next_cyc(); nop(); ex_br_taken = 1'b0;
        exp_out("br2_valid", S_V, 12); exp_out("br2_flush", S_FL, 0); drain();
        next_cyc(); nop(); exp_out("br3_valid", S_V, 9); drain();
        next_cyc(); nop(); exp_out("br4_valid", S_V, 3); drain();
        next_cyc(); nop(); drain();

        // Freeze for 3 cycles with a pending forward and a redirect during busy
        next_cyc(); drive(0, 0, 0, 0, 12, 1, 0); exp_out("fz_pre_valid", S_V, 15); drain();
        next_cyc(); drive(0, 0, 0, 0, 11, 1, 0); drain();
        next_cyc(); drive(11, 1, 0, 0, 15, 1, 0); drain();
        for (int i = 0; i < 3; i++) begin
            next_cyc(); nop(); mem_busy = 1'b1; ex_br_taken = (i > 0);
            exp_out("fz_valid", S_V, 15); exp_out("fz_fwd_a", S_FA, 2);
            exp_out("fz_fwd_b", S_FB, 0); exp_out("fz_freeze", S_FZ, 1);
            exp_out("fz_stall_if", S_SIF, 1); exp_out("fz_stall_de", S_SDE, 0);
            exp_out("fz_flush", S_FL, 0); exp_out("fz_rf_we", S_WE, 1);
            drain();
        end
        next_cyc(); mem_busy = 1'b0; ex_br_taken = 1'b1;
        exp_out("fzend_valid", S_V, 15); exp_out("fzend_fwd_a", S_FA, 2);
        exp_out("fzend_flush", S_FL, 1); exp_out("fzend_freeze", S_FZ, 0);
        exp_out("fzend_stall_if", S_SIF, 0); drain();
        next_cyc(); ex_br_taken = 1'b0;
        exp_out("fzpost_valid", S_V, 12); exp_out("fzpost_rf_we", S_WE, 1);
        exp_out("fzpost_fwd_a", S_FA, 0); drain();

        // Reset mid-operation
        next_cyc(); RESET = 1'b1; drain();
        next_cyc();
        exp_out("mid_rst_valid", S_V, 0); exp_out("mid_rst_we", S_WE, 0);
        exp_out("mid_rst_valid5", S_V2, 0); drain();
        RESET = 1'b0;

        // 5-stage instance, load result available from stage 4: two stall cycles
        next_cyc(); drive(2, 1, 0, 0, 7, 1, 1); exp_out("p5_valid1", S_V2, 1); drain();
        next_cyc(); drive(7, 1, 7, 1, 8, 1, 0);
        exp_out("p5_stall_if_a", S_SIF2, 1); exp_out("p5_stall_de_a", S_SDE2, 1);
        exp_out("p5_valid2", S_V2, 3); drain();
        next_cyc(); drive(7, 1, 7, 1, 8, 1, 0);
        exp_out("p5_stall_if_b", S_SIF2, 1); exp_out("p5_stall_de_b", S_SDE2, 1);
        exp_out("p5_valid3", S_V2, 5); drain();
        next_cyc(); drive(7, 1, 7, 1, 8, 1, 0);
        exp_out("p5_stall_if_c", S_SIF2, 0); exp_out("p5_stall_de_c", S_SDE2, 0);
        exp_out("p5_valid4", S_V2, 9); drain();
        next_cyc(); nop();
        exp_out("p5_fwd_a", S_FA2, 4); exp_out("p5_fwd_b", S_FB2, 4);
        exp_out("p5_valid5", S_V2, 19); exp_out("p5_rf_we", S_WE2, 1); drain();

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
